// File: rtl/fetch_pkg.sv
// Shared types for the fetch PC unit: PC width, PC type and next-PC source encoding.
package fetch_pkg;
  localparam int unsigned PC_W = 11;

  typedef logic [PC_W-1:0] pc_t;

  typedef enum logic [2:0] {
    SEL_SEQ,
    SEL_PRED,
    SEL_IRQ,
    SEL_JMP,
    SEL_RET,
    SEL_CNI,
    SEL_PBT
  } npc_sel_e;
endpackage

// File: rtl/fetch_npc_mux.sv
// Combinational next-PC priority selector. Interrupt entry/return paths exist only
// when FETCH_ISR_EN is defined.
module fetch_npc_mux
  import fetch_pkg::*;
#(
  parameter pc_t ISR_VECTOR = 11'h7C0
) (
  input  pc_t        if_pc,
  input  logic       if_is_comp,
  input  logic       if_prediction,
  input  pc_t        if_pbt,
  input  logic       id_valid,
  input  logic       id_is_jump,
  input  logic       id_jump_in_bht,
  input  pc_t        id_branchtarget,
  input  logic [1:0] exe_correction,
  input  pc_t        exe_cni,
  input  pc_t        exe_pbt,
  input  logic       irq_req,
  input  logic       isr_running,
  input  logic       id_is_uret,
  input  pc_t        epc,
  output npc_sel_e   sel,
  output pc_t        npc,
  output pc_t        fall_pc
);

`ifndef FETCH_ISR_EN
  logic unused_isr;
  assign unused_isr = ^{irq_req, isr_running, id_is_uret, epc};
`endif

  // Sources are applied lowest priority first so each later assignment overrides.
  always_comb begin
    fall_pc = if_prediction ? if_pbt
                            : if_pc + (if_is_comp ? pc_t'(1) : pc_t'(2));
    sel     = if_prediction ? SEL_PRED : SEL_SEQ;
    npc     = fall_pc;
`ifdef FETCH_ISR_EN
    if (irq_req && !isr_running) begin
      sel = SEL_IRQ;
      npc = ISR_VECTOR;
    end
`endif
    if (id_valid && id_is_jump && !id_jump_in_bht) begin
      sel = SEL_JMP;
      npc = id_branchtarget;
    end
`ifdef FETCH_ISR_EN
    if (id_valid && id_is_uret) begin
      sel = SEL_RET;
      npc = epc;
    end
`endif
    if (exe_correction == 2'b10) begin
      sel = SEL_CNI;
      npc = exe_cni;
    end
    if (exe_correction == 2'b11) begin
      sel = SEL_PBT;
      npc = exe_pbt;
    end
  end
endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch PC generator and IF->ID->EXE PC/valid pipe with predictor redirects.
// Optional interrupt entry/return enabled by FETCH_ISR_EN.
module fetch_pc_unit
  import fetch_pkg::*;
#(
  parameter pc_t RESET_PC   = 11'h000,
  parameter pc_t ISR_VECTOR = 11'h7C0
) (
  input  logic       CLK,
  input  logic       nrst,
  input  logic       en,
  input  logic       stall,
  input  logic       if_is_comp,
  input  logic       if_prediction,
  input  pc_t        if_PBT,
  input  logic       id_is_jump,
  input  logic       id_jump_in_bht,
  input  pc_t        id_branchtarget,
  input  logic [1:0] exe_correction,
  input  pc_t        exe_CNI,
  input  pc_t        exe_PBT,
  input  logic       irq_req,
  input  logic       id_is_uret,
  output pc_t        if_PC,
  output pc_t        id_PC,
  output pc_t        exe_PC,
  output logic       id_valid,
  output logic       exe_valid,
  output logic       ISR_running,
  output pc_t        epc
);

  npc_sel_e sel;
  pc_t      npc;
  pc_t      fall_pc;
  logic     adv;
  logic     corr;

  assign adv  = en && !stall;
  assign corr = en && exe_correction[1];

  fetch_npc_mux #(
    .ISR_VECTOR(ISR_VECTOR)
  ) u_npc_mux (
    .if_pc           (if_PC),
    .if_is_comp      (if_is_comp),
    .if_prediction   (if_prediction),
    .if_pbt          (if_PBT),
    .id_valid        (id_valid),
    .id_is_jump      (id_is_jump),
    .id_jump_in_bht  (id_jump_in_bht),
    .id_branchtarget (id_branchtarget),
    .exe_correction  (exe_correction),
    .exe_cni         (exe_CNI),
    .exe_pbt         (exe_PBT),
    .irq_req         (irq_req),
    .isr_running     (ISR_running),
    .id_is_uret      (id_is_uret),
    .epc             (epc),
    .sel             (sel),
    .npc             (npc),
    .fall_pc         (fall_pc)
  );

  // A correction is honoured even under stall; the PC pipe only shifts if not stalled.
  always_ff @(posedge CLK or negedge nrst) begin
    if (!nrst) begin
      if_PC     <= RESET_PC;
      id_PC     <= '0;
      exe_PC    <= '0;
      id_valid  <= 1'b0;
      exe_valid <= 1'b0;
    end else if (corr) begin
      if_PC     <= npc;
      id_valid  <= 1'b0;
      exe_valid <= 1'b0;
      if (!stall) begin
        id_PC  <= if_PC;
        exe_PC <= id_PC;
      end
    end else if (adv) begin
      if_PC     <= npc;
      id_PC     <= if_PC;
      exe_PC    <= id_PC;
      exe_valid <= id_valid;
      id_valid  <= !(sel inside {SEL_RET, SEL_JMP, SEL_IRQ});
    end
  end

`ifdef FETCH_ISR_EN
  always_ff @(posedge CLK or negedge nrst) begin
    if (!nrst) begin
      ISR_running <= 1'b0;
      epc         <= '0;
    end else if (adv) begin
      if (sel == SEL_IRQ) begin
        ISR_running <= 1'b1;
        epc         <= fall_pc;
      end else if (sel == SEL_RET) begin
        ISR_running <= 1'b0;
      end
    end
  end
`else
  assign ISR_running = 1'b0;
  assign epc         = '0;
`endif
endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit: reference model plus per-cycle compare and literal checks.
module tb_fetch_pc_unit;
  import fetch_pkg::*;

  logic       CLK = 1'b0;
  logic       nrst = 1'b0;
  logic       en = 1'b1, stall = 1'b0, if_is_comp = 1'b0, if_prediction = 1'b0;
  pc_t        if_PBT = '0, id_branchtarget = '0, exe_CNI = '0, exe_PBT = '0;
  logic       id_is_jump = 1'b0, id_jump_in_bht = 1'b0;
  logic [1:0] exe_correction = 2'b00;
  logic       irq_req = 1'b0, id_is_uret = 1'b0;
  pc_t        if_PC, id_PC, exe_PC, epc;
  logic       id_valid, exe_valid, ISR_running;

  int n_cmp = 0;
  int n_err = 0;

`ifdef FETCH_ISR_EN
  localparam bit ISR_BUILD = 1'b1;
`else
  localparam bit ISR_BUILD = 1'b0;
`endif

  fetch_pc_unit #(.RESET_PC(11'h000), .ISR_VECTOR(11'h7C0)) dut (
    .CLK(CLK), .nrst(nrst), .en(en), .stall(stall), .if_is_comp(if_is_comp),
    .if_prediction(if_prediction), .if_PBT(if_PBT), .id_is_jump(id_is_jump),
    .id_jump_in_bht(id_jump_in_bht), .id_branchtarget(id_branchtarget),
    .exe_correction(exe_correction), .exe_CNI(exe_CNI), .exe_PBT(exe_PBT),
    .irq_req(irq_req), .id_is_uret(id_is_uret), .if_PC(if_PC), .id_PC(id_PC),
    .exe_PC(exe_PC), .id_valid(id_valid), .exe_valid(exe_valid),
    .ISR_running(ISR_running), .epc(epc)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [10:0] ifpc, idpc, expc, epc;
    logic        idv, exv, isr;
  } mstate_t;

  localparam mstate_t M_RESET = '{ifpc: 11'h000, idpc: 11'h000, expc: 11'h000,
                                  epc: 11'h000, idv: 1'b0, exv: 1'b0, isr: 1'b0};

  mstate_t m = M_RESET;

  function automatic mstate_t model_next(mstate_t s);
    mstate_t n;
    int      fall;
    int      target;
    bit      kill_all, kill_id, take_irq, do_ret;
    n = s;
    kill_all = 1'b0; kill_id = 1'b0; take_irq = 1'b0; do_ret = 1'b0;
    fall = if_prediction ? int'(if_PBT) : (int'(s.ifpc) + (if_is_comp ? 1 : 2)) % 2048;
    target = fall;
    if (exe_correction == 2'b11) begin target = int'(exe_PBT); kill_all = 1'b1; end
    else if (exe_correction == 2'b10) begin target = int'(exe_CNI); kill_all = 1'b1; end
    else if (ISR_BUILD && s.idv && id_is_uret) begin target = int'(s.epc); kill_id = 1'b1; do_ret = 1'b1; end
    else if (s.idv && id_is_jump && !id_jump_in_bht) begin target = int'(id_branchtarget); kill_id = 1'b1; end
    else if (ISR_BUILD && irq_req && !s.isr) begin target = 'h7C0; kill_id = 1'b1; take_irq = 1'b1; end
    if (!en) return s;
    if (stall && !kill_all) return s;
    n.ifpc = 11'(target);
    if (kill_all) begin
      n.idv = 1'b0;
      n.exv = 1'b0;
      if (!stall) begin n.idpc = s.ifpc; n.expc = s.idpc; end
      return n;
    end
    n.idpc = s.ifpc;
    n.expc = s.idpc;
    n.exv  = s.idv;
    n.idv  = !kill_id;
    if (take_irq) begin n.isr = 1'b1; n.epc = 11'(fall); end
    if (do_ret) n.isr = 1'b0;
    return n;
  endfunction

  always @(posedge CLK or negedge nrst) begin
    if (!nrst) m <= M_RESET;
    else       m <= model_next(m);
  end

  task automatic chk(input string nm, input logic [10:0] act, input logic [10:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    chk("model if_PC", if_PC, m.ifpc);
    chk("model id_PC", id_PC, m.idpc);
    chk("model exe_PC", exe_PC, m.expc);
    chk("model id_valid", 11'(id_valid), 11'(m.idv));
    chk("model exe_valid", 11'(exe_valid), 11'(m.exv));
    chk("model ISR_running", 11'(ISR_running), 11'(m.isr));
    chk("model epc", epc, m.epc);
  end

  task automatic step();
    @(posedge CLK);
    #2;
  endtask

  initial begin
    step();
    step();
    nrst = 1'b1;
    chk("reset if_PC", if_PC, 11'h000);
    chk("reset id_valid", 11'(id_valid), 11'h0);
    chk("reset exe_valid", 11'(exe_valid), 11'h0);
    chk("reset epc", epc, 11'h000);

    // sequential fetch
    if_is_comp = 1'b0; step();
    chk("seq1 if_PC", if_PC, 11'h002);
    chk("seq1 id_PC", id_PC, 11'h000);
    step();
    chk("seq2 if_PC", if_PC, 11'h004);
    chk("seq2 exe_PC", exe_PC, 11'h000);
    if_is_comp = 1'b1; step();
    chk("seq3 if_PC", if_PC, 11'h005);
    chk("seq3 id_PC", id_PC, 11'h004);
    chk("seq3 exe_PC", exe_PC, 11'h002);

    // prediction then correction
    if_is_comp = 1'b0; if_prediction = 1'b1; if_PBT = 11'h120; step();
    chk("pred if_PC", if_PC, 11'h120);
    if_prediction = 1'b0; step(); step();
    chk("pred+2 if_PC", if_PC, 11'h124);
    exe_correction = 2'b10; exe_CNI = 11'h00A; step();
    chk("cni if_PC", if_PC, 11'h00A);
    chk("cni id_valid", 11'(id_valid), 11'h0);
    chk("cni exe_valid", 11'(exe_valid), 11'h0);
    exe_correction = 2'b00; step(); step();
    chk("post-cni if_PC", if_PC, 11'h00E);

    // uncached jump
    id_is_jump = 1'b1; id_jump_in_bht = 1'b0; id_branchtarget = 11'h300; step();
    chk("jmp if_PC", if_PC, 11'h300);
    chk("jmp id_valid", 11'(id_valid), 11'h0);
    chk("jmp exe_valid", 11'(exe_valid), 11'h1);
    id_is_jump = 1'b0;

    // stall with correction, then plain stall, then disabled
    stall = 1'b1; exe_correction = 2'b11; exe_PBT = 11'h055; step();
    chk("stallcorr if_PC", if_PC, 11'h055);
    chk("stallcorr id_PC", id_PC, 11'h00E);
    chk("stallcorr id_valid", 11'(id_valid), 11'h0);
    chk("stallcorr exe_valid", 11'(exe_valid), 11'h0);
    exe_correction = 2'b00; step(); step();
    chk("stall hold if_PC", if_PC, 11'h055);
    chk("stall hold id_PC", id_PC, 11'h00E);
    stall = 1'b0; en = 1'b0; step();
    chk("en hold if_PC", if_PC, 11'h055);
    en = 1'b1;

    // wrap-around
    if_prediction = 1'b1; if_PBT = 11'h7FF; step();
    if_prediction = 1'b0; step();
    chk("wrap if_PC", if_PC, 11'h001);

`ifdef FETCH_ISR_EN
    if_prediction = 1'b1; if_PBT = 11'h010; step();
    if_prediction = 1'b0; irq_req = 1'b1; step();
    chk("irq if_PC", if_PC, 11'h7C0);
    chk("irq epc", epc, 11'h012);
    chk("irq ISR_running", 11'(ISR_running), 11'h1);
    irq_req = 1'b0; step();
    id_is_uret = 1'b1; step();
    chk("uret if_PC", if_PC, 11'h012);
    chk("uret ISR_running", 11'(ISR_running), 11'h0);
    id_is_uret = 1'b0;
    irq_req = 1'b1; exe_correction = 2'b10; exe_CNI = 11'h040; step();
    chk("irq+cni if_PC", if_PC, 11'h040);
    chk("irq+cni ISR_running", 11'(ISR_running), 11'h0);
    exe_correction = 2'b00; step();
    chk("irq retry if_PC", if_PC, 11'h7C0);
    chk("irq retry epc", epc, 11'h042);
    irq_req = 1'b0; step();
    id_is_uret = 1'b1; step();
    chk("uret2 if_PC", if_PC, 11'h042);
    id_is_uret = 1'b0;
`endif

    // asynchronous reset mid-operation while disabled
    step();
    en = 1'b0;
    nrst = 1'b0; #1;
    chk("async rst if_PC", if_PC, 11'h000);
    chk("async rst id_PC", id_PC, 11'h000);
    chk("async rst exe_valid", 11'(exe_valid), 11'h0);
    en = 1'b1;
    step();
    nrst = 1'b1; step();
    chk("post rst if_PC", if_PC, 11'h002);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/fetch_pc_unit.md
# fetch_pc_unit

Generates the instruction-fetch PC every cycle and carries it down the IF→ID→EXE pipeline, applying the redirects produced by the branch predictor. It consumes `if_prediction`, `if_PBT`, `exe_correction`, `exe_CNI`, `exe_PBT` and `id_jump_in_bht`. It produces the `if_PC`, `id_PC` and `exe_PC` halfword addresses that the predictor looks up. Optional interrupt entry and return logic also drives `ISR_running`.

## Interface
- `RESET_PC`, 11'h000: halfword address fetched after reset.
- `ISR_VECTOR`, 11'h7C0: halfword address of the interrupt handler.
- `CLK` in 1: sole clock, rising edge.
- `nrst` in 1: reset, asynchronous, active-low.
- `en` in 1: global enable; when low, all state holds.
- `stall` in 1: pipeline stall; PC and pipe registers hold.
- `if_is_comp` in 1: fetched instruction is 16-bit (+1), else 32-bit (+2).
- `if_prediction` in 1, `if_PBT` in 11: predictor outputs for IF.
- `id_is_jump` in 1, `id_jump_in_bht` in 1, `id_branchtarget` in 11: ID-stage jump information.
- `exe_correction` in 2, `exe_CNI` in 11, `exe_PBT` in 11: EXE-stage mispredict correction.
- `irq_req` in 1, `id_is_uret` in 1: interrupt request, and return-from-ISR decoded in ID.
- `if_PC`, `id_PC`, `exe_PC` out 11: per-stage halfword PCs.
- `id_valid`, `exe_valid` out 1: the stage holds a live (unkilled) instruction.
- `ISR_running` out 1: handler active.
- `epc` out 11: saved return PC.

## Operation
- **Next-PC priority** (highest first):
  1. `exe_correction`=2'b11 → `exe_PBT`.
  2. `exe_correction`=2'b10 → `exe_CNI`.
  3. `id_valid && id_is_uret` → `epc` (ISR builds only).
  4. `id_valid && id_is_jump && !id_jump_in_bht` → `id_branchtarget`.
  5. IRQ accept → `ISR_VECTOR`.
  6. `if_prediction` → `if_PBT`.
  7. Otherwise `if_PC + (if_is_comp ? 1 : 2)`.
- **Address arithmetic:** all addresses are 11-bit; the increment wraps modulo 2^11 (11'h7FF+1 → 11'h000).
- **Pipe advance:** each advancing cycle, `id_PC`←`if_PC` and `exe_PC`←`id_PC`, with the valid bits following.
- **Kills:**
  - Priority 1/2: `id_valid`←0 and `exe_valid`←0.
  - Priority 3/4: `id_valid`←0; `exe_valid` takes the ID instruction.
- **IRQ accept:** condition is `irq_req && !ISR_running && exe_correction[1]==0` with no priority-3/4 redirect. On accept:
  - `epc`←the sequential/predicted PC that would otherwise have been selected;
  - `ISR_running`←1;
  - `id_valid`←0.
- **Return:** priority 3 clears `ISR_running`.
- **Simultaneous events:** a higher-priority redirect suppresses IRQ accept. The request stays pending; it is level-sensitive and is retried the next cycle.

## Timing
- **Reset values:**
  - `if_PC`=`RESET_PC`, `id_PC`=`exe_PC`=0;
  - `id_valid`=`exe_valid`=0;
  - `ISR_running`=0, `epc`=0.
- **Reset mid-operation:** immediate reset, independent of `en`/`stall`.
- **Redirect latency:** one cycle. The selected next PC appears on `if_PC` the edge after the redirect inputs are sampled.
- **Update gating:**
  - All registers update only when `en && !stall`.
  - Exception: `exe_correction[1]` redirects update even under `stall`, so a correction is never lost. In that case `id_valid`/`exe_valid` are cleared and the PC pipe does not shift.
- **Flush signal:** `flush` from the predictor is not consumed. Kills are derived locally from the same inputs.

## Configuration
- Macro: `FETCH_ISR_EN`.
- **Defined:** priority 3 and 5 paths present; `ISR_running`/`epc` are registers.
- **Undefined:**
  - `irq_req`/`id_is_uret` are ignored;
  - `ISR_running` and `epc` are tied to 0;
  - priority list reduces to 1, 2, 4, 6, 7.

## Structure
- **Shared package `fetch_pkg`:**
  - `PC_W`=11;
  - typedef `pc_t` = logic [PC_W-1:0];
  - enum `npc_sel_e` {SEL_SEQ, SEL_PRED, SEL_IRQ, SEL_JMP, SEL_RET, SEL_CNI, SEL_PBT}.
- **Sub-module `fetch_npc_mux`:** purely combinational priority selector that returns `npc_sel_e` and the next PC. The top level holds all registers.

## Test plan
- **Reset then sequential fetch:** release `nrst`, `if_is_comp`=0,0,1 → `if_PC`=000,002,004,005; `id_PC` lags by one cycle and `exe_PC` by two.
- **Prediction, then correction:** `if_prediction`=1, `if_PBT`=0x120 → `if_PC`=0x120. Two cycles later, `exe_correction`=2'b10 with `exe_CNI`=0x00A → `if_PC`=0x00A and `id_valid`=`exe_valid`=0 next cycle.
- **Uncached jump:** `id_is_jump`=1, `id_jump_in_bht`=0, `id_branchtarget`=0x300 → `if_PC`=0x300, `id_valid`=0, `exe_valid`=1.
- **Stall plus correction:** `stall`=1 with `exe_correction`=2'b11, `exe_PBT`=0x055 → `if_PC`=0x055 and both valid bits cleared. With `stall`=1 and no correction, all outputs hold.
- **IRQ round-trip (`FETCH_ISR_EN`):**
  - At `if_PC`=0x010, 32-bit instruction, `irq_req`=1 → `if_PC`=0x7C0, `epc`=0x012, `ISR_running`=1.
  - Later `id_is_uret` → `if_PC`=0x012, `ISR_running`=0.
  - `irq_req` in the same cycle as `exe_correction`=2'b10 → correction wins; IRQ is taken the following cycle.
- **Wrap-around:** `if_PC`=0x7FF, `if_is_comp`=0 → next `if_PC`=0x001.
